// File: rtl/p_div_pkg.sv
// p_div_pkg: shared packed-arithmetic definitions (pw one-hot bit positions, lane width table, lane masks).
package p_div_pkg;
    localparam int PW_32 = 0;
    localparam int PW_16 = 1;
    localparam int PW_8  = 2;
    localparam int PW_4  = 3;
    localparam int PW_2  = 4;

    function automatic logic [5:0] lane_width(input logic [4:0] pw);
        return pw[PW_2] ? 6'd2 : pw[PW_4] ? 6'd4 : pw[PW_8] ? 6'd8 : pw[PW_16] ? 6'd16 : 6'd32;
    endfunction

    function automatic logic [31:0] lane_msb(input logic [4:0] pw);
        return pw[PW_2] ? 32'hAAAA_AAAA : pw[PW_4] ? 32'h8888_8888 :
               pw[PW_8] ? 32'h8080_8080 : pw[PW_16] ? 32'h8000_8000 : 32'h8000_0000;
    endfunction

    function automatic logic [31:0] lane_lsb(input logic [4:0] pw);
        return (lane_msb(pw) << 1) | 32'd1;
    endfunction
endpackage

// File: rtl/p_addsub.sv
// p_addsub: packed ripple adder/subtractor; carry[i] is the carry out of bit i, so a lane's carry-out sits at its MSB.
module p_addsub
    import p_div_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  pw,
    input  logic        sub,
    output logic [31:0] sum,
    output logic [31:0] carry
);
    logic [31:0] lsb;
    logic        cin;
    logic        bb;

    assign lsb = lane_lsb(pw);

    always_comb begin
        sum   = '0;
        carry = '0;
        cin   = sub;
        bb    = 1'b0;
        for (int i = 0; i < 32; i++) begin
            cin      = lsb[i] ? sub : cin;
            bb       = b[i] ^ sub;
            sum[i]   = a[i] ^ bb ^ cin;
            cin      = (a[i] & bb) | (cin & (a[i] ^ bb));
            carry[i] = cin;
        end
    end
endmodule

// File: rtl/p_div.sv
// p_div: packed unsigned restoring divider, one quotient bit per lane per cycle.
module p_div
    import p_div_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic        valid,
    input  logic        div,
    input  logic [4:0]  pw,
    input  logic [31:0] crs1,
    input  logic [31:0] crs2,
    output logic        ready,
    output logic [31:0] result
);
    logic [5:0]  count;
    logic [5:0]  w;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] msb;
    logic [31:0] lsb;
    logic [31:0] rem_in;
    logic [31:0] quo_in;
    logic [31:0] rem_sh;
    logic [31:0] trial;
    logic [31:0] carry;
    logic [31:0] q_msb;
    logic [31:0] sel;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;
    logic        cur;

    assign w      = lane_width(pw);
    assign msb    = lane_msb(pw);
    assign lsb    = lane_lsb(pw);
    assign rem_in = (count == 6'd0) ? '0 : rem;
    assign quo_in = (count == 6'd0) ? crs1 : quo;
    // Lane MSBs of quo drop into the LSBs of the same lanes of rem; lsb mask blocks cross-lane bits.
    assign rem_sh = ((rem_in << 1) & ~lsb) | ((quo_in & msb) >> (w - 6'd1));

    p_addsub u_sub (
        .a     (rem_sh),
        .b     (crs2),
        .pw    (pw),
        .sub   (1'b1),
        .sum   (trial),
        .carry (carry)
    );

    // Quotient bit per lane at its MSB: ext (old rem MSB) or no borrow.
    assign q_msb = msb & (rem_in | carry);

    always_comb begin
        sel = '0;
        cur = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            cur    = msb[i] ? q_msb[i] : cur;
            sel[i] = cur;
        end
    end

    assign rem_nx = (trial & sel) | (rem_sh & ~sel);
    assign quo_nx = ((quo_in << 1) & ~lsb) | (q_msb >> (w - 6'd1));
    assign ready  = valid && (count == w);
    assign result = div ? quo : rem;

    always_ff @(posedge clock) begin
        if (!resetn || !valid || ready) begin
            count <= '0;
            rem   <= '0;
            quo   <= '0;
        end else if (count < w) begin
            count <= count + 6'd1;
            rem   <= rem_nx;
            quo   <= quo_nx;
        end
    end
endmodule

// File: tb/tb_p_div.sv
// tb_p_div: directed and randomized checks of p_div against a per-lane arithmetic model.
module tb_p_div;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        valid = 1'b0;
    logic        div = 1'b0;
    logic [4:0]  pw = 5'b00001;
    logic [31:0] crs1 = '0;
    logic [31:0] crs2 = '0;
    logic        ready;
    logic [31:0] result;
    int checks = 0;
    int failures = 0;

    p_div dut (
        .clock  (clock),
        .resetn (resetn),
        .valid  (valid),
        .div    (div),
        .pw     (pw),
        .crs1   (crs1),
        .crs2   (crs2),
        .ready  (ready),
        .result (result)
    );

    always #5 clock = ~clock;

    function automatic int width_of(input logic [4:0] p);
        return p[4] ? 2 : p[3] ? 4 : p[2] ? 8 : p[1] ? 16 : 32;
    endfunction

    function automatic logic [31:0] model(input logic [4:0] p, input logic [31:0] a, input logic [31:0] b, input logic d);
        int w;
        longint unsigned m, x, y, r;
        logic [31:0] out;
        w = width_of(p);
        m = (64'd1 << w) - 64'd1;
        out = '0;
        for (int l = 0; l < 32 / w; l++) begin
            x = (64'(a) >> (l * w)) & m;
            y = (64'(b) >> (l * w)) & m;
            r = (y == 0) ? (d ? m : x) : (d ? x / y : x % y);
            out |= 32'(r << (l * w));
        end
        return out;
    endfunction

    // Holds valid with the given operands until ready (or a 40-cycle budget); leaves at posedge+1.
    task automatic run_op(input logic [4:0] p, input logic [31:0] a, input logic [31:0] b, input logic d,
                          output logic [31:0] r, output int lat);
        pw = p; crs1 = a; crs2 = b; div = d; valid = 1'b1;
        lat = 0;
        r = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (ready) begin
                lat = k;
                r = result;
                break;
            end
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic test_reset;
        resetn = 1'b0; valid = 1'b1; pw = 5'b00001;
        @(posedge clock); #1;
        @(posedge clock); #1;
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready_valid1 got=%b want=0", ready); end
        valid = 1'b0;
        @(negedge clock);
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready_valid0 got=%b want=0", ready); end
        @(posedge clock); #1;
        resetn = 1'b1;
        idle(1);
    endtask

    task automatic test_directed;
        logic [31:0] r;
        int lat;
        run_op(5'b00001, 32'd100, 32'd7, 1'b1, r, lat); idle(1);
        checks++; if (lat !== 33) begin failures++; $display("FAIL w32_latency got=%0d want=33", lat); end
        checks++; if (r !== 32'd14) begin failures++; $display("FAIL w32_quo got=%h want=%h", r, 32'd14); end
        run_op(5'b00001, 32'd100, 32'd7, 1'b0, r, lat); idle(1);
        checks++; if (r !== 32'd2) begin failures++; $display("FAIL w32_rem got=%h want=%h", r, 32'd2); end
        run_op(5'b00001, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1, r, lat); idle(1);
        checks++; if (r !== 32'd1) begin failures++; $display("FAIL ext_quo got=%h want=1", r); end
        run_op(5'b00001, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, r, lat); idle(1);
        checks++; if (r !== 32'h7FFF_FFFE) begin failures++; $display("FAIL ext_rem got=%h want=7ffffffe", r); end
        run_op(5'b00100, 32'hFF64_1007, 32'h100A_0302, 1'b1, r, lat); idle(1);
        checks++; if (lat !== 9) begin failures++; $display("FAIL w8_latency got=%0d want=9", lat); end
        checks++; if (r !== 32'h0F0A_0503) begin failures++; $display("FAIL w8_quo got=%h want=0f0a0503", r); end
        run_op(5'b00100, 32'hFF64_1007, 32'h100A_0302, 1'b0, r, lat); idle(1);
        checks++; if (r !== 32'h0F00_0101) begin failures++; $display("FAIL w8_rem got=%h want=0f000101", r); end
        run_op(5'b00010, 32'h1234_5678, 32'h0000_0003, 1'b1, r, lat); idle(1);
        checks++; if (lat !== 17) begin failures++; $display("FAIL w16_latency got=%0d want=17", lat); end
        checks++; if (r !== 32'hFFFF_1CD2) begin failures++; $display("FAIL div0_quo got=%h want=ffff1cd2", r); end
        run_op(5'b00010, 32'h1234_5678, 32'h0000_0003, 1'b0, r, lat); idle(1);
        checks++; if (r !== 32'h1234_0002) begin failures++; $display("FAIL div0_rem got=%h want=12340002", r); end
        run_op(5'b10000, 32'hFFFF_FFFF, 32'h5555_5555, 1'b1, r, lat); idle(1);
        checks++; if (lat !== 3) begin failures++; $display("FAIL w2_latency got=%0d want=3", lat); end
        checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL w2_quo got=%h want=ffffffff", r); end
        run_op(5'b10000, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, r, lat); idle(1);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL w2_rem got=%h want=0", r); end
    endtask

    task automatic test_abort;
        logic [31:0] r;
        int lat;
        int seen;
        pw = 5'b00001; crs1 = 32'hDEAD_BEEF; crs2 = 32'd13; div = 1'b1; valid = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clock);
            if (ready) seen++;
            @(posedge clock); #1;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL abort_early_ready got=%0d want=0", seen); end
        idle(1);
        run_op(5'b00001, 32'd100, 32'd7, 1'b1, r, lat); idle(1);
        checks++; if (lat !== 33) begin failures++; $display("FAIL abort_latency got=%0d want=33", lat); end
        checks++; if (r !== 32'd14) begin failures++; $display("FAIL abort_quo got=%h want=%h", r, 32'd14); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r;
        int lat;
        run_op(5'b00100, 32'hFF64_1007, 32'h100A_0302, 1'b1, r, lat);
        checks++; if (lat !== 9 || r !== 32'h0F0A_0503) begin failures++; $display("FAIL b2b_first lat=%0d res=%h want lat=9 res=0f0a0503", lat, r); end
        run_op(5'b00100, 32'hFF64_1007, 32'h100A_0302, 1'b1, r, lat); idle(1);
        checks++; if (lat !== 9 || r !== 32'h0F0A_0503) begin failures++; $display("FAIL b2b_second lat=%0d res=%h want lat=9 res=0f0a0503", lat, r); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] r;
        int lat;
        int seen;
        pw = 5'b00100; crs1 = 32'hFF64_1007; crs2 = 32'h100A_0302; div = 1'b0; valid = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clock);
            if (ready) seen++;
            @(posedge clock); #1;
        end
        resetn = 1'b0;
        repeat (2) begin
            @(negedge clock);
            if (ready) seen++;
            @(posedge clock); #1;
        end
        resetn = 1'b1;
        checks++; if (seen !== 0) begin failures++; $display("FAIL rstmid_ready got=%0d want=0", seen); end
        run_op(5'b00100, 32'hFF64_1007, 32'h100A_0302, 1'b0, r, lat); idle(1);
        checks++; if (lat !== 9 || r !== 32'h0F00_0101) begin failures++; $display("FAIL rstmid_next lat=%0d res=%h want lat=9 res=0f000101", lat, r); end
    endtask

    task automatic test_random;
        logic [31:0] r, a, b, exp;
        logic [4:0] p;
        logic d;
        int lat;
        for (int n = 0; n < 40; n++) begin
            p = 5'b00001 << $urandom_range(0, 4);
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) b = b & ~((32'd1 << width_of(p)) - 32'd1) & ((width_of(p) == 32) ? 32'h0 : 32'hFFFF_FFFF);
            d = 1'($urandom_range(0, 1));
            exp = model(p, a, b, d);
            run_op(p, a, b, d, r, lat);
            if ($urandom_range(0, 1) == 0) idle(1);
            checks++;
            if (lat !== width_of(p) + 1 || r !== exp)
                begin failures++; $display("FAIL rand pw=%b a=%h b=%h div=%b lat=%0d res=%h want lat=%0d res=%h", p, a, b, d, lat, r, width_of(p) + 1, exp); end
        end
        idle(1);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_abort;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/p_div.md
P_DIV -- requirements
Module: p_div

Interface
REQ-001 SHALL have port clock, input, 1 bit, the rising-edge clock for all state.
REQ-002 SHALL have port resetn, input, 1 bit, the reset: synchronous, active-low.
REQ-003 SHALL have port valid, input, 1 bit, which requests an operation; it is held high until ready.
REQ-004 SHALL have port ready, output, 1 bit, a single-cycle pulse that marks result as valid.
REQ-005 SHALL have port div, input, 1 bit: 1 selects quotient, 0 selects remainder.
REQ-006 SHALL have port pw, input, 5 bits, one-hot lane width: bit0=32, bit1=16, bit2=8, bit3=4, bit4=2.
REQ-007 SHALL have port crs1, input, 32 bits, the packed unsigned dividends.
REQ-008 SHALL have port crs2, input, 32 bits, the packed unsigned divisors.
REQ-009 SHALL have port result, output, 32 bits, the packed quotients or remainders.

Function
REQ-010 SHALL perform independent unsigned restoring division in every lane of width W selected by pw.
REQ-011 SHALL keep a 6-bit step counter, count, and registers rem[31:0] (packed partial remainders) and quo[31:0] (packed dividend/quotient shift register).
REQ-012 SHALL, in each cycle with valid=1 and count<W, execute one step in every lane and increment count.
REQ-013 SHALL execute each lane step as follows:
- shift the rem lane left 1, bringing in the MSB of the quo lane; keep the bit shifted out as ext.
- trial = shifted rem − divisor lane.
- if ext=1 or there is no borrow: rem lane = trial and quotient bit = 1; otherwise rem lane = shifted value and quotient bit = 0.
- shift the quo lane left 1, inserting the quotient bit at the LSB.
REQ-014 SHALL keep all shifts lane-local; no bit crosses a lane boundary.
REQ-015 SHALL take the step inputs at count=0 as rem=0 and quo=crs1, regardless of register contents.
REQ-016 SHALL assert ready combinationally when valid=1 and count==W, so ready rises on the (W+1)th valid cycle.
REQ-017 SHALL drive result = div ? quo : rem; it is defined only while ready=1.
REQ-018 SHALL, on the cycle after ready, clear count, rem and quo; if valid is still high, a new operation starts with the current operands.
REQ-019 SHALL clear count, rem and quo in any cycle where valid=0; an operation abandoned mid-way leaves no residue.
REQ-020 SHALL, for divisor lane = 0, produce quotient lane = all ones and remainder lane = the dividend lane; this falls out of REQ-013 with no special case.
REQ-021 SHALL make outputs undefined while operands, pw or div change during valid=1; the issuing stage holds them stable.
REQ-022 SHALL make behaviour undefined for a non-one-hot pw.

Reset
REQ-023 SHALL, with resetn=0 at a clock edge, set count=0, rem=0 and quo=0; ready=0 follows next cycle unless W=0, which cannot occur.
REQ-024 SHALL give reset priority over valid; a reset mid-operation aborts the operation, and no ready is produced for it.

Structure
REQ-025 SHALL take the pw one-hot bit positions and the lane-width table (W per pw bit) from the shared packed-arithmetic defines header, also used by the packed add and multiply units.
REQ-026 SHALL perform the trial subtraction with one instance of the existing packed adder, p_addsub, with sub=1.
REQ-027 SHALL derive no-borrow from p_addsub per-lane carry-out = 1 at each lane MSB.
REQ-028 SHALL generate the lane-local shift masks from pw inside p_div.

Verification
REQ-029 SHALL cover: pw=00001, crs1=100, crs2=7 -> ready on 33rd cycle; div=1 gives 14, div=0 gives 2. Also crs1=0xFFFFFFFF, crs2=0x80000001 -> q=1, r=0x7FFFFFFE (exercises ext).
REQ-030 SHALL cover: pw=00100, crs1=0xFF641007, crs2=0x100A0302 -> ready on 9th cycle; q=0x0F0A0503, r=0x0F000101.
REQ-031 SHALL cover: pw=00010, crs1=0x12345678, crs2=0x00000003 (upper lane divides by zero) -> q=0xFFFF1CD2, r=0x12340002.
REQ-032 SHALL cover: pw=10000, crs1=0xFFFFFFFF, crs2=0x55555555 -> ready on 3rd cycle; q=0xFFFFFFFF, r=0.
REQ-033 SHALL cover: pw=00001, valid dropped at count=5 then re-raised with crs1=100, crs2=7 -> ready exactly 33 cycles after re-raise, q=14.
REQ-034 SHALL cover: valid held high across two back-to-back pw=00100 operations -> two ready pulses 9 cycles apart, both results correct; resetn pulsed mid-operation -> no ready, and the next operation is correct.
